// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: packs HPS ioctl ROM bytes into 16-bit SDRAM writes and captures DIP bytes.
module ioctl_rom_loader #(
  parameter logic [15:0] ROM_INDEX   = 16'd0,
  parameter logic [15:0] DIP_INDEX   = 16'd254,
  parameter logic [26:0] MAX_BYTES   = 27'h0200000,
  parameter logic [23:0] DIP_DEFAULT = 24'hFFFFFF
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST_n,
  input  logic [15:0] i_IOCTL_INDEX,
  input  logic        i_IOCTL_DOWNLOAD,
  input  logic [26:0] i_IOCTL_ADDR,
  input  logic [7:0]  i_IOCTL_DATA,
  input  logic        i_IOCTL_WR,
  output logic        o_IOCTL_WAIT,
  output logic        o_SDRAM_REQ,
  output logic [25:0] o_SDRAM_ADDR,
  output logic [15:0] o_SDRAM_DATA,
  input  logic        i_SDRAM_ACK,
  output logic [23:0] o_DIPSW,
  output logic        o_ROM_LOADED,
  output logic        o_LOAD_DONE,
  output logic        o_OVERRUN
);
  typedef enum logic [2:0] {IDLE, COLLECT, REQ, FLUSH, DONE} state_t;
  state_t      r_state;
  logic        r_dl_d, r_start_pend, r_pend, r_flushing, r_req, r_loaded, r_done, r_ovr;
  logic [7:0]  r_low;
  logic [25:0] r_low_addr, r_addr;
  logic [15:0] r_data;
  logic [23:0] r_dip;
  logic        w_rom_rise, w_rom_wr, w_dip_wr;
  assign w_rom_rise = i_IOCTL_DOWNLOAD & ~r_dl_d & (i_IOCTL_INDEX == ROM_INDEX);
  assign w_rom_wr   = i_IOCTL_WR & i_IOCTL_DOWNLOAD & (i_IOCTL_INDEX == ROM_INDEX) & (i_IOCTL_ADDR < MAX_BYTES);
  assign w_dip_wr   = i_IOCTL_WR & i_IOCTL_DOWNLOAD & (i_IOCTL_INDEX == DIP_INDEX) & (i_IOCTL_ADDR < 27'd3);
  assign o_IOCTL_WAIT = r_req;
  assign o_SDRAM_REQ  = r_req;
  assign o_SDRAM_ADDR = r_addr;
  assign o_SDRAM_DATA = r_data;
  assign o_DIPSW      = r_dip;
  assign o_ROM_LOADED = r_loaded;
  assign o_LOAD_DONE  = r_done;
  assign o_OVERRUN    = r_ovr;
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_state      <= IDLE;
      r_dl_d       <= 1'b0;
      r_start_pend <= 1'b0;
      r_pend       <= 1'b0;
      r_flushing   <= 1'b0;
      r_req        <= 1'b0;
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
      r_ovr        <= 1'b0;
      r_low        <= 8'h00;
      r_low_addr   <= 26'd0;
      r_addr       <= 26'd0;
      r_data       <= 16'h0000;
      r_dip        <= DIP_DEFAULT;
    end else begin
      r_dl_d <= i_IOCTL_DOWNLOAD;
      r_done <= 1'b0;
      if (w_dip_wr) r_dip[{i_IOCTL_ADDR[1:0], 3'b000} +: 8] <= i_IOCTL_DATA;
      // a start seen while finishing the previous load is replayed from IDLE
      if (w_rom_rise && r_state != IDLE) r_start_pend <= 1'b1;
      case (r_state)
        IDLE: if (w_rom_rise || r_start_pend) begin
          r_state      <= COLLECT;
          r_loaded     <= 1'b0;
          r_ovr        <= 1'b0;
          r_pend       <= 1'b0;
          r_start_pend <= 1'b0;
        end
        COLLECT: if (w_rom_wr && !i_IOCTL_ADDR[0]) begin
          r_low      <= i_IOCTL_DATA;
          r_low_addr <= i_IOCTL_ADDR[26:1];
          r_pend     <= 1'b1;
        end else if (w_rom_wr) begin
          r_addr     <= i_IOCTL_ADDR[26:1];
          r_data     <= {i_IOCTL_DATA, r_pend ? r_low : 8'hFF};
          r_req      <= 1'b1;
          r_pend     <= 1'b0;
          r_flushing <= 1'b0;
          r_state    <= REQ;
        end else if (!i_IOCTL_DOWNLOAD) r_state <= FLUSH;
        REQ: begin
          if (w_rom_wr) r_ovr <= 1'b1;
          if (i_SDRAM_ACK) begin
            r_req   <= 1'b0;
            r_state <= (r_flushing || !i_IOCTL_DOWNLOAD) ? FLUSH : COLLECT;
          end
        end
        FLUSH: if (r_pend) begin
          r_addr     <= r_low_addr;
          r_data     <= {8'hFF, r_low};
          r_req      <= 1'b1;
          r_pend     <= 1'b0;
          r_flushing <= 1'b1;
          r_state    <= REQ;
        end else r_state <= DONE;
        DONE: begin
          r_done   <= 1'b1;
          r_loaded <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_rom_loader.sv
// tb_ioctl_rom_loader: table, directed and randomized checks against a byte-list reference model.
module tb_ioctl_rom_loader;
  localparam logic [26:0] MAXB = 27'h0200000;
  typedef struct { logic [26:0] a; logic [7:0] d; logic [23:0] exp; } dip_t;
  logic        clk = 0, rst_n = 0, dl = 0, wr = 0, ack = 0;
  logic [15:0] idx = 0;
  logic [26:0] addr = 0;
  logic [7:0]  data = 0;
  logic        o_wait, o_req, o_loaded, o_done, o_ovr;
  logic [25:0] o_addr;
  logic [15:0] o_data;
  logic [23:0] o_dip;
  int vec = 0, miss = 0, ack_dly = 0, done_cnt = 0, rcnt = 0;
  bit ack_off = 0;
  logic [41:0] wq[$], expq[$];
  logic [26:0] ba[$];
  logic [7:0]  bd[$];
  ioctl_rom_loader dut (
    .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .i_IOCTL_INDEX(idx), .i_IOCTL_DOWNLOAD(dl),
    .i_IOCTL_ADDR(addr), .i_IOCTL_DATA(data), .i_IOCTL_WR(wr), .o_IOCTL_WAIT(o_wait),
    .o_SDRAM_REQ(o_req), .o_SDRAM_ADDR(o_addr), .o_SDRAM_DATA(o_data), .i_SDRAM_ACK(ack),
    .o_DIPSW(o_dip), .o_ROM_LOADED(o_loaded), .o_LOAD_DONE(o_done), .o_OVERRUN(o_ovr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // SDRAM side: accept each request after ack_dly cycles and log what was written
  initial forever begin
    tick();
    ack = 0;
    if (o_req && !ack_off) begin
      if (rcnt >= ack_dly) begin
        ack = 1;
        wq.push_back({o_addr, o_data});
        rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
  end
  initial begin
    logic [41:0] prev = 0;
    bit prev_req = 0, ack_seen = 0;
    forever begin
      @(negedge clk);
      if (o_done) done_cnt++;
      check("wait_eq_req", o_wait, o_req);
      if (ack_seen) check("ack_to_wait_low", o_wait, 1'b0);
      if (prev_req && o_req) check("req_hold", {o_addr, o_data}, prev);
      ack_seen = ack && o_req && rst_n;
      prev_req = o_req;
      prev = {o_addr, o_data};
    end
  end
  task automatic pulse(input logic [26:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    wr = 1;
    tick();
    wr = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (o_wait && n < 200) begin
      tick();
      n++;
    end
    check("wait_timeout", o_wait, 1'b0);
  endtask
  task automatic send(input logic [26:0] a, input logic [7:0] d);
    pulse(a, d);
    check("req_latency", o_req, (idx == 16'd0 && a < MAXB && a[0]));
    wait_idle();
  endtask
  task automatic start(input logic [15:0] i);
    idx = i;
    dl = 1;
    tick();
    tick();
  endtask
  task automatic finish_rom();
    int n = 0;
    int d0 = done_cnt;
    dl = 0;
    while (!o_loaded && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("load_done_pulses", done_cnt - d0, 1);
    check("rom_loaded", o_loaded, 1'b1);
  endtask
  task automatic model();
    logic [7:0]  lo = 0;
    logic [26:0] la = 0;
    bit p = 0;
    expq.delete();
    for (int i = 0; i < ba.size(); i++) if (ba[i] < MAXB) begin
      if (ba[i][0]) begin
        expq.push_back({ba[i][26:1], bd[i], p ? lo : 8'hFF});
        p = 0;
      end else begin
        lo = bd[i];
        la = ba[i];
        p = 1;
      end
    end
    if (p) expq.push_back({la[26:1], 8'hFF, lo});
  endtask
  task automatic compare_writes(input string tag);
    check({tag, "_count"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++) check({tag, "_word"}, wq[i], expq[i]);
  endtask
  task automatic rom_run(input string tag);
    wq.delete();
    model();
    start(16'd0);
    for (int i = 0; i < ba.size(); i++) send(ba[i], bd[i]);
    finish_rom();
    compare_writes(tag);
    check({tag, "_overrun"}, o_ovr, 1'b0);
  endtask
  initial begin
    dip_t dt[5];
    dt[0] = '{27'd0, 8'h12, 24'hFFFF12};
    dt[1] = '{27'd1, 8'h34, 24'hFF3412};
    dt[2] = '{27'd2, 8'h56, 24'h563412};
    dt[3] = '{27'd3, 8'h78, 24'h563412};
    dt[4] = '{27'd5, 8'h9A, 24'h563412};
    repeat (3) tick();
    check("rst_req", o_req, 1'b0);
    check("rst_dip", o_dip, 24'hFFFFFF);
    check("rst_loaded", o_loaded, 1'b0);
    check("rst_ovr", o_ovr, 1'b0);
    rst_n = 1;
    tick();
    check("rst_done", o_done, 1'b0);
    check("rst_wait", o_wait, 1'b0);
    ack_dly = 3;
    ba = '{27'd0, 27'd1, 27'd2, 27'd3};
    bd = '{8'h11, 8'h22, 8'h33, 8'h44};
    rom_run("t1");
    check("t1_w0", wq[0], {26'd0, 16'h2211});
    check("t1_w1", wq[1], {26'd1, 16'h4433});
    ack_dly = 1;
    ba = '{27'd0, 27'd1, 27'd2};
    bd = '{8'hAA, 8'hBB, 8'hCC};
    rom_run("t2");
    check("t2_flush", wq[1], {26'd1, 16'hFFCC});
    wq.delete();
    ack_dly = 5;
    start(16'd0);
    check("t3_ovr_clear", o_ovr, 1'b0);
    send(27'd0, 8'h01);
    pulse(27'd1, 8'h02);
    pulse(27'd2, 8'h99);
    check("t3_ovr_set", o_ovr, 1'b1);
    wait_idle();
    send(27'd4, 8'h55);
    send(27'd5, 8'h66);
    finish_rom();
    expq = '{{26'd0, 16'h0201}, {26'd2, 16'h6655}};
    compare_writes("t3");
    check("t3_ovr_sticky", o_ovr, 1'b1);
    wq.delete();
    start(16'd254);
    for (int i = 0; i < 5; i++) begin
      send(dt[i].a, dt[i].d);
      check("dipsw", o_dip, dt[i].exp);
    end
    dl = 0;
    repeat (3) tick();
    check("dip_no_writes", wq.size(), 0);
    check("dip_keeps_loaded", o_loaded, 1'b1);
    start(16'd7);
    send(27'd0, 8'h00);
    send(27'd1, 8'h11);
    dl = 0;
    repeat (3) tick();
    check("other_idx_writes", wq.size(), 0);
    check("other_idx_dip", o_dip, 24'h563412);
    ack_dly = 0;
    ba = '{27'h1FFFFE, 27'h1FFFFF, 27'h200001, 27'h200000, 27'h200003};
    bd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    rom_run("t5");
    for (int r = 0; r < 20; r++) begin
      logic [26:0] a;
      int len, c;
      ack_dly = $urandom_range(0, 4);
      len = $urandom_range(0, 12);
      a = (r % 5 == 0) ? MAXB - 27'd6 : 27'($urandom_range(0, 100) * 2);
      ba.delete();
      bd.delete();
      for (int j = 0; j < len; j++) begin
        ba.push_back(a);
        bd.push_back(8'($urandom));
        c = $urandom_range(0, 9);
        a = (c == 9) ? a : (c == 8) ? a + 27'd2 : a + 27'd1;
      end
      rom_run("rand");
    end
    start(16'd0);
    ack_off = 1;
    pulse(27'd0, 8'h5A);
    pulse(27'd1, 8'hA5);
    check("t6_req_up", o_req, 1'b1);
    #2 rst_n = 0;
    #1;
    check("t6_req", o_req, 1'b0);
    check("t6_wait", o_wait, 1'b0);
    check("t6_loaded", o_loaded, 1'b0);
    check("t6_dip", o_dip, 24'hFFFFFF);
    dl = 0;
    ack_off = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    ack_dly = 2;
    ba = '{27'd6, 27'd7, 27'd8};
    bd = '{8'hC3, 8'h3C, 8'h7E};
    rom_run("t6");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
